// File: rtl/adpll_pi.sv
// All-digital PLL core: multiplier phase detector, cascaded accumulate-and-dump
// decimators, saturating PI loop filter, lock detector. Optional: ADPLL_PI_ANTIWINDUP_EN.
module adpll_pi #(
  parameter int DW       = 16,
  parameter int DEC_LOG2 = 3,
  parameter int STAGES   = 3,
  parameter int OW       = 24,
  parameter int KP_SH    = 4,
  parameter int KI_SH    = 0,
  parameter int LOCK_TH  = 64,
  parameter int LOCK_CNT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [OW-1:0] df,
  output logic                 df_valid,
  output logic signed [DW-1:0] err,
  output logic                 locked
);

  localparam int DEC = 1 << DEC_LOG2;
  localparam int AW  = DW + DEC_LOG2;
  localparam int CW  = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam int SH  = (KP_SH > KI_SH) ? KP_SH : KI_SH;
  localparam int IW  = OW + SH + 2;
  localparam int LCW = $clog2(LOCK_CNT + 1);

  localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  function automatic logic signed [OW-1:0] sat(input logic signed [IW-1:0] v);
    if (v > MAXV)      return OW'(MAXV);
    else if (v < MINV) return OW'(MINV);
    else               return OW'(v);
  endfunction

  // Phase detector: keep the top DW bits of the exact 2*DW product.
  logic signed [2*DW-1:0] w_prod;
  logic signed [DW-1:0]   r_p;
  logic                   r_pv;

  assign w_prod = a * b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p  <= '0;
      r_pv <= 1'b0;
    end else begin
      r_pv <= in_valid;
      if (in_valid) r_p <= DW'(w_prod >>> DW);
    end
  end

  // Decimator chain; element k feeds stage k, element STAGES is the filter input.
  logic signed [DW-1:0] w_sx [STAGES+1];
  logic                 w_sv [STAGES+1];

  assign w_sx[0] = r_p;
  assign w_sv[0] = r_pv;

  for (genvar k = 0; k < STAGES; k++) begin : g_dec
    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_sum;
    logic [CW-1:0]        r_cnt;
    logic signed [DW-1:0] r_out;
    logic                 r_ov;

    assign w_sum = r_acc + AW'(w_sx[k]);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_out <= '0;
        r_ov  <= 1'b0;
      end else begin
        r_ov <= 1'b0;
        if (w_sv[k]) begin
          if (r_cnt == CW'(DEC - 1)) begin
            r_out <= DW'(w_sum >>> DEC_LOG2);
            r_acc <= '0;
            r_cnt <= '0;
            r_ov  <= 1'b1;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end

    assign w_sx[k+1] = r_out;
    assign w_sv[k+1] = r_ov;
  end

  // Loop filter
  logic signed [DW-1:0] w_e;
  logic                 w_ev;
  logic signed [IW-1:0] w_eext;
  logic signed [IW-1:0] w_ki;
  logic signed [IW-1:0] w_kp;
  logic signed [OW-1:0] r_int;
  logic signed [IW-1:0] w_isum;
  logic signed [OW-1:0] w_inew;
  logic signed [IW-1:0] w_dsum;
  logic                 w_hold;

  assign w_e    = w_sx[STAGES];
  assign w_ev   = w_sv[STAGES];
  assign w_eext = IW'(w_e);
  assign w_ki   = w_eext <<< KI_SH;
  assign w_kp   = w_eext <<< KP_SH;
  assign w_isum = IW'(r_int) + w_ki;

`ifdef ADPLL_PI_ANTIWINDUP_EN
  // Flags describe the previous df; the integrator freezes while e pushes further into the rail.
  logic r_sat_pos;
  logic r_sat_neg;

  assign w_hold = (r_sat_pos && (w_e > 0)) || (r_sat_neg && (w_e < 0));
`else
  assign w_hold = 1'b0;
`endif

  assign w_inew = w_hold ? r_int : sat(w_isum);
  assign w_dsum = IW'(w_inew) + w_kp;

  // Lock detector; |e| is DW+1 bits so the most negative sample has a true magnitude.
  logic [DW:0]     w_abs;
  logic [LCW-1:0]  r_lcnt;
  logic [LCW-1:0]  w_lnext;

  assign w_abs   = w_e[DW-1] ? (DW+1)'(-(DW+1)'(w_e)) : (DW+1)'(w_e);
  assign w_lnext = (r_lcnt == LCW'(LOCK_CNT)) ? r_lcnt : r_lcnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      df       <= '0;
      df_valid <= 1'b0;
      err      <= '0;
      locked   <= 1'b0;
      r_int    <= '0;
      r_lcnt   <= '0;
`ifdef ADPLL_PI_ANTIWINDUP_EN
      r_sat_pos <= 1'b0;
      r_sat_neg <= 1'b0;
`endif
    end else begin
      df_valid <= 1'b0;
      if (w_ev) begin
        df_valid <= 1'b1;
        err      <= w_e;
        r_int    <= w_inew;
        df       <= sat(w_dsum);
`ifdef ADPLL_PI_ANTIWINDUP_EN
        r_sat_pos <= (w_dsum > MAXV);
        r_sat_neg <= (w_dsum < MINV);
`endif
        if (w_abs < (DW+1)'(LOCK_TH)) begin
          r_lcnt <= w_lnext;
          locked <= (w_lnext == LCW'(LOCK_CNT));
        end else begin
          r_lcnt <= '0;
          locked <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adpll_pi.sv
// Directed bench for adpll_pi: table of {stimulus, update count, expected df/err/locked}
// plus hand sequences for latency, input gaps and mid-accumulation reset.
module tb_adpll_pi;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic signed [23:0] df;
  logic               df_valid;
  logic signed [15:0] err;
  logic               locked;

  adpll_pi #(
    .DW(16), .DEC_LOG2(2), .STAGES(2), .OW(24),
    .KP_SH(4), .KI_SH(0), .LOCK_TH(64), .LOCK_CNT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .df(df), .df_valid(df_valid), .err(err), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ADPLL_PI_ANTIWINDUP_EN
  localparam int EXP_UNWIND = 8253440;
`else
  localparam int EXP_UNWIND = 8318975;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_upd  = 0;
  int t_last = 0;
  logic signed [23:0] m_df;
  logic signed [15:0] m_err;
  logic               m_lock;
  int                 m_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (df_valid) begin
      n_upd  <= n_upd + 1;
      m_df   <= df;
      m_err  <= err;
      m_lock <= locked;
      m_cyc  <= cyc;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic signed [15:0] va, input logic signed [15:0] vb,
                       input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = va;
      b        = vb;
      t_last   = cyc;
      if (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    bit                 rst;
    logic signed [15:0] va;
    logic signed [15:0] vb;
    int                 nupd;
    int                 exp_df;
    int                 exp_err;
    bit                 exp_lock;
  } vec_t;

  vec_t tv[10];
  int   base;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;

    tv[0] = '{1'b1, 16'sd16384,  16'sd16384,    1,   69632,  4096, 1'b0};
    tv[1] = '{1'b0, 16'sd16384,  16'sd16384,    1,   73728,  4096, 1'b0};
    tv[2] = '{1'b1, 16'sd16384, -16'sd16384,    1,  -69632, -4096, 1'b0};
    tv[3] = '{1'b1, 16'sd640,    16'sd1024,     3,     190,    10, 1'b0};
    tv[4] = '{1'b0, 16'sd640,    16'sd1024,     1,     200,    10, 1'b1};
    tv[5] = '{1'b0, 16'sd6400,   16'sd1024,     1,    1740,   100, 1'b0};
    tv[6] = '{1'b1, 16'sd16384,  16'sd16384, 2031, 8384512,  4096, 1'b0};
    tv[7] = '{1'b0, 16'sd16384,  16'sd16384,    1, 8388607,  4096, 1'b0};
    tv[8] = '{1'b0, 16'sd16384,  16'sd16384,   68, 8388607,  4096, 1'b0};
    tv[9] = '{1'b0, 16'sd16384, -16'sd16384,    1, EXP_UNWIND, -4096, 1'b0};

    do_reset();
    chk("reset_df", df, 0);
    chk("reset_df_valid", df_valid, 0);
    chk("reset_err", err, 0);
    chk("reset_locked", locked, 0);

    for (int i = 0; i < 10; i++) begin
      if (tv[i].rst) do_reset();
      base = n_upd;
      drive(tv[i].va, tv[i].vb, 16 * tv[i].nupd, 1'b0);
      drain();
      chk($sformatf("row%0d_count", i), n_upd - base, tv[i].nupd);
      chk($sformatf("row%0d_df", i), m_df, tv[i].exp_df);
      chk($sformatf("row%0d_err", i), m_err, tv[i].exp_err);
      chk($sformatf("row%0d_locked", i), m_lock, tv[i].exp_lock);
    end

    // Continuous-input latency from the 16th sample.
    do_reset();
    drive(16'sd16384, 16'sd16384, 16, 1'b0);
    drain();
    chk("latency_cont", m_cyc - t_last, 4);

    // Every-other-cycle input gives the same df sequence and latency.
    do_reset();
    base = n_upd;
    drive(16'sd16384, 16'sd16384, 16, 1'b1);
    drain();
    chk("gap_latency", m_cyc - t_last, 4);
    chk("gap_df1", m_df, 69632);
    drive(16'sd16384, 16'sd16384, 16, 1'b1);
    drain();
    chk("gap_df2", m_df, 73728);
    chk("gap_count", n_upd - base, 2);

    // Reset mid-accumulation discards partial sums and the integrator.
    do_reset();
    drive(16'sd16384, 16'sd16384, 16, 1'b0);
    drain();
    drive(16'sd16384, 16'sd16384, 10, 1'b0);
    do_reset();
    chk("midrst_df", df, 0);
    chk("midrst_err", err, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_df_valid", df_valid, 0);
    base = n_upd;
    drive(16'sd16384, 16'sd16384, 15, 1'b0);
    drain();
    chk("midrst_no_early", n_upd - base, 0);
    drive(16'sd16384, 16'sd16384, 1, 1'b0);
    drain();
    chk("midrst_count", n_upd - base, 1);
    chk("midrst_df_after", m_df, 69632);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adpll_pi.md
# adpll_pi

Parametrised all-digital PLL core: multiplier phase detector, cascaded accumulate-and-dump decimators, and a saturating PI loop filter with a lock detector. It sits between the sampled reference/local-oscillator streams and the NCO frequency-control word. It replaces per-stage derived clocks with one clock plus sample-valid strobes.

## Interface
- DW, 16: sample width of `a`, `b`, and the filtered error `err`
- DEC_LOG2, 3: log2 of the decimation factor per stage (DEC = 2^DEC_LOG2, ≥1)
- STAGES, 3: number of cascaded decimation stages (1..4)
- OW, 24: output word width (OW ≥ DW)
- KP_SH, 4: proportional gain, as a left shift
- KI_SH, 0: integral gain, as a left shift
- LOCK_TH, 64: lock threshold on |err| (strict less-than)
- LOCK_CNT, 16: number of consecutive in-threshold updates required for lock
- clk, in, 1: system clock
- rst_n, in, 1: reset, synchronous, active-low
- in_valid, in, 1: `a`/`b` sample strobe
- a, in, DW: reference sample, signed
- b, in, DW: local (NCO) sample, signed
- df, out, OW: frequency-correction word, signed
- df_valid, out, 1: one-cycle strobe, `df` updated
- err, out, DW: last filtered phase error, signed
- locked, out, 1: lock indicator

## Operation
- **Phase detector:** on `in_valid`, register p = (a*b) >>> DW (arithmetic, DW bits). The product is exact at 2·DW. p_valid follows one cycle later.
- **Decimator stage k:**
  - Accumulator is DW+DEC_LOG2 bits signed; counter runs 0..DEC-1.
  - On input valid with cnt<DEC-1: acc += x, cnt++.
  - On input valid with cnt==DEC-1: out <= (acc+x) >>> DEC_LOG2, acc <= 0, cnt <= 0, out_valid pulses next cycle.
  - Shift truncates toward −∞. No overflow is possible.
- **Loop filter:** on final-stage valid, with e = stage output:
  - err <= e.
  - I' = sat(I + (e <<< KI_SH)).
  - df <= sat(I' + (e <<< KP_SH)).
  - I <= I'.
  - Intermediates are OW+max(KP_SH,KI_SH)+2 bits.
  - sat clamps to [−2^(OW-1), 2^(OW-1)−1].
- **Lock detector:** on each loop update:
  - If |e| < LOCK_TH: cnt = min(cnt+1, LOCK_CNT); locked=1 once cnt reaches LOCK_CNT.
  - Otherwise: cnt=0, locked=0.
  - |−2^(DW-1)| is treated as 2^(DW-1).
- **Gaps:** `in_valid` gaps of any length are allowed; state holds while `in_valid`=0.

## Timing
- **Reset values:** df=0, df_valid=0, err=0, locked=0. All accumulators, counters, and the integrator are cleared.
- **Reset mid-accumulation:** partial sums are discarded. The next df_valid requires DEC^STAGES fresh samples.
- **Latency:** df_valid asserts STAGES+2 cycles after the `in_valid` cycle carrying the DEC^STAGES-th sample.
- **Update timing:** `err`, `df`, and `locked` update in the same cycle df_valid asserts. They hold until the next update.
- **Throughput:** one sample per cycle (`in_valid` may stay high continuously); one df per DEC^STAGES samples.
- **No back-pressure:** df_valid is a pulse, and the consumer must sample it.

## Configuration
- **ADPLL_PI_ANTIWINDUP_EN defined:** the integrator update is skipped when the previous df was saturated and e has the same sign as that saturation. df is still recomputed from the held I.
- **ADPLL_PI_ANTIWINDUP_EN undefined:** the integrator always updates, clamped by its own saturation.

## Test plan
All scenarios use DW=16, DEC_LOG2=2, STAGES=2, OW=24, KP_SH=4, KI_SH=0, LOCK_TH=64, LOCK_CNT=4, with `in_valid` continuously high unless noted.
- **Constant positive error:** a=b=16384, so e=4096. First df_valid 4 cycles after the 16th sample: df=69632, err=4096. Second update: df=73728.
- **Sign:** a=16384, b=−16384. First update: err=−4096, df=−69632.
- **Saturation/anti-windup, flag undefined:** hold e=4096 for 2100 updates → df=8388607. Then e=−4096 → df=8318975.
- **Saturation/anti-windup, flag defined:** same stimulus. df first saturates at update 2032 and I holds at 8323072. Then e=−4096 → df=8253440.
- **Lock:** a=640, b=1024 (e=10) → locked rises with the 4th df_valid. Then a=6400 (e=100) → locked falls on the next df_valid.
- **Gaps and reset:**
  - `in_valid` high every other cycle with a=b=16384 → same df sequence as the first scenario, with the first strobe 4 cycles after the 16th valid sample.
  - Pulse rst_n low after 10 samples → outputs go to 0. The next df_valid needs 16 new samples, and df=69632.
